// File: rtl/counters_bank.sv
// Bank of per-channel event counters with saturate/wrap mode, sticky overflow, clear-on-read and a running total.
// Read latency 1 cycle after an accepted req in IDLE; no backpressure, a held req reads every cycle.
module counters_bank #(
  parameter int NUM_CH      = 5,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 5,
  parameter int SATURATE    = 1,
  parameter int CLR_ON_READ = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  counts,
  output logic              counts_valid,
  output logic [CNT_W+2:0]  counts_total,
  output logic [NUM_CH-1:0] ovf,
  output logic              idx_err
);

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [CNT_W+2:0] TMAX   = '1;
  localparam logic [IDX_W:0]   NCH_IX = (IDX_W+1)'(NUM_CH);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] ovf_set;
  logic [CNT_W-1:0]  rd_val;
  logic [CNT_W+3:0]  pc;
  logic [CNT_W+3:0]  tot_sum;
  logic [CNT_W+2:0]  tot_nxt;
  logic              clr_st;
  logic              count_en;
  logic              rd_acc;
  logic              idx_ok;

  assign clr_st   = (state == ST_RESET) || (state == ST_INIT);
  assign count_en = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign rd_acc   = (state == ST_IDLE) && req;
  assign idx_ok   = ({1'b0, idx} < NCH_IX);

  always_comb begin
    rd_val = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (idx == IDX_W'(ch)) rd_val = cnt[ch];
    end
  end

  // A cleared-on-read counter restarts from 0 so a same-cycle pop still lands as 1.
  always_comb begin
    ovf_set = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic [CNT_W-1:0] base;
      base = cnt[ch];
      if ((CLR_ON_READ != 0) && rd_acc && idx_ok && (idx == IDX_W'(ch))) base = '0;
      cnt_nxt[ch] = base;
      if (pop[ch]) begin
        if (base == CMAX) begin
          ovf_set[ch] = 1'b1;
          cnt_nxt[ch] = (SATURATE != 0) ? CMAX : '0;
        end else begin
          cnt_nxt[ch] = base + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pc = pc + {{(CNT_W+3){1'b0}}, pop[ch]};
    end
    tot_sum = {1'b0, counts_total} + pc;
    if (tot_sum[CNT_W+3] && (SATURATE != 0)) tot_nxt = TMAX;
    else                                     tot_nxt = tot_sum[CNT_W+2:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_L || clr_st) begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] <= '0;
      ovf          <= '0;
      counts_total <= '0;
      counts       <= '0;
      counts_valid <= 1'b0;
      idx_err      <= 1'b0;
    end else begin
      counts_valid <= rd_acc;
      idx_err      <= rd_acc && !idx_ok;
      if (rd_acc) counts <= idx_ok ? rd_val : '0;
      if (count_en) begin
        for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] <= cnt_nxt[ch];
        ovf          <= ovf | ovf_set;
        counts_total <= tot_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counters_bank.sv
// Two differently parametrised banks driven by the same stimulus, each checked every cycle against a behavioural model.
module tb_counters_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic [3:0] state;
  logic [4:0] pop;
  logic       req;
  logic [2:0] idx;

  logic [4:0] a_counts; logic a_valid; logic [7:0] a_total; logic [4:0] a_ovf; logic a_err;
  logic [4:0] b_counts; logic b_valid; logic [7:0] b_total; logic [3:0] b_ovf; logic b_err;

  counters_bank #(.NUM_CH(5), .IDX_W(3), .CNT_W(5), .SATURATE(1), .CLR_ON_READ(0)) dut_a (
    .clk(clk), .reset_L(reset_L), .state(state), .pop(pop), .req(req), .idx(idx),
    .counts(a_counts), .counts_valid(a_valid), .counts_total(a_total), .ovf(a_ovf), .idx_err(a_err));

  counters_bank #(.NUM_CH(4), .IDX_W(3), .CNT_W(5), .SATURATE(0), .CLR_ON_READ(1)) dut_b (
    .clk(clk), .reset_L(reset_L), .state(state), .pop(pop[3:0]), .req(req), .idx(idx),
    .counts(b_counts), .counts_valid(b_valid), .counts_total(b_total), .ovf(b_ovf), .idx_err(b_err));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nch(input int i);  return (i == 0) ? 5 : 4; endfunction
  function automatic bit sat(input int i);  return (i == 0);         endfunction
  function automatic bit clrr(input int i); return (i != 0);         endfunction

  int m_cnt[2][8];
  int m_ovf[2], m_tot[2], m_counts[2], m_valid[2], m_err[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_L || state == 4'b0001 || state == 4'b0010) begin
        for (int c = 0; c < 8; c++) m_cnt[i][c] = 0;
        m_ovf[i] = 0; m_tot[i] = 0; m_counts[i] = 0; m_valid[i] = 0; m_err[i] = 0;
      end else begin
        bit rd;
        int t;
        rd = (state == 4'b0100) && req;
        m_valid[i] = rd ? 1 : 0;
        m_err[i]   = (rd && int'(idx) >= nch(i)) ? 1 : 0;
        if (rd) m_counts[i] = (int'(idx) < nch(i)) ? m_cnt[i][int'(idx)] : 0;
        if (state == 4'b0100 || state == 4'b1000) begin
          t = m_tot[i];
          for (int c = 0; c < nch(i); c++) begin
            int v;
            v = m_cnt[i][c];
            if (rd && clrr(i) && int'(idx) == c) v = 0;
            if (pop[c]) begin
              t++;
              if (v == 31) begin
                m_ovf[i] = m_ovf[i] | (1 << c);
                v = sat(i) ? 31 : 0;
              end else v++;
            end
            m_cnt[i][c] = v;
          end
          if (t > 255) t = sat(i) ? 255 : t - 256;
          m_tot[i] = t;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_counts", int'(a_counts), m_counts[0]);
    chk("a_valid",  int'(a_valid),  m_valid[0]);
    chk("a_total",  int'(a_total),  m_tot[0]);
    chk("a_ovf",    int'(a_ovf),    m_ovf[0]);
    chk("a_idx_err",int'(a_err),    m_err[0]);
    chk("b_counts", int'(b_counts), m_counts[1]);
    chk("b_valid",  int'(b_valid),  m_valid[1]);
    chk("b_total",  int'(b_total),  m_tot[1]);
    chk("b_ovf",    int'(b_ovf),    m_ovf[1]);
    chk("b_idx_err",int'(b_err),    m_err[1]);
  end

  task automatic tick(input logic rl, input logic [3:0] st, input logic [4:0] pp,
                      input logic rq, input logic [2:0] ix);
    reset_L = rl; state = st; pop = pp; req = rq; idx = ix;
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] S_RST = 4'b0001, S_INI = 4'b0010, S_IDL = 4'b0100, S_ACT = 4'b1000;

  initial begin
    tick(0, S_RST, 5'b0, 0, 0);
    tick(0, S_RST, 5'b0, 0, 0);
    chk("lit_rst_valid", int'(a_valid), 0);
    chk("lit_rst_total", int'(a_total), 0);
    chk("lit_rst_ovf",   int'(a_ovf),   0);
    chk("lit_rst_counts",int'(a_counts),0);

    // count and back-to-back reads
    repeat (3) tick(1, S_ACT, 5'b00001, 0, 0);
    tick(1, S_ACT, 5'b00100, 0, 0);
    tick(1, S_IDL, 5'b0, 1, 0);
    chk("lit_rd0_counts", int'(a_counts), 3);
    chk("lit_rd0_valid",  int'(a_valid),  1);
    tick(1, S_IDL, 5'b0, 1, 2);
    chk("lit_rd2_counts", int'(a_counts), 1);
    chk("lit_rd2_valid",  int'(a_valid),  1);
    tick(1, S_IDL, 5'b0, 0, 0);
    chk("lit_idle_valid", int'(a_valid), 0);
    chk("lit_total4",     int'(a_total), 4);

    // saturate (A) vs wrap (B)
    repeat (33) tick(1, S_ACT, 5'b00010, 0, 0);
    tick(1, S_IDL, 5'b0, 1, 1);
    chk("lit_sat_counts",  int'(a_counts), 31);
    chk("lit_sat_ovf1",    int'(a_ovf[1]), 1);
    chk("lit_wrap_counts", int'(b_counts), 1);
    chk("lit_wrap_ovf1",   int'(b_ovf[1]), 1);
    chk("lit_total37",     int'(a_total), 37);

    // clear via INIT state, then clear-on-read collision
    tick(1, S_INI, 5'b0, 0, 0);
    chk("lit_init_total", int'(a_total), 0);
    chk("lit_init_ovf",   int'(b_ovf),   0);
    repeat (5) tick(1, S_ACT, 5'b01000, 0, 0);
    tick(1, S_IDL, 5'b01000, 1, 3);
    chk("lit_cor_b5", int'(b_counts), 5);
    chk("lit_cor_a5", int'(a_counts), 5);
    tick(1, S_IDL, 5'b0, 1, 3);
    chk("lit_cor_b1", int'(b_counts), 1);
    chk("lit_cor_a6", int'(a_counts), 6);

    // out-of-range and ACTIVE-state reads
    tick(1, S_IDL, 5'b0, 1, 4);
    chk("lit_oor_b_counts", int'(b_counts), 0);
    chk("lit_oor_b_valid",  int'(b_valid),  1);
    chk("lit_oor_b_err",    int'(b_err),    1);
    chk("lit_inr_a_err",    int'(a_err),    0);
    tick(1, S_IDL, 5'b0, 1, 5);
    chk("lit_oor_a_err",    int'(a_err),    1);
    tick(1, S_ACT, 5'b0, 1, 3);
    chk("lit_act_a_valid",  int'(a_valid),  0);
    chk("lit_act_b_valid",  int'(b_valid),  0);
    tick(1, S_IDL, 5'b0, 1, 3);
    chk("lit_unchanged_a3", int'(a_counts), 6);

    // reset on the same edge as an accepted read and pop
    tick(1, S_ACT, 5'b11111, 0, 0);
    tick(1, S_ACT, 5'b11111, 0, 0);
    tick(0, S_IDL, 5'b00001, 1, 0);
    chk("lit_mid_valid", int'(a_valid), 0);
    chk("lit_mid_total", int'(a_total), 0);
    tick(1, S_IDL, 5'b0, 1, 0);
    chk("lit_mid_cnt0",  int'(a_counts), 0);
    chk("lit_mid_vld",   int'(a_valid),  1);

    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] st;
      r = $urandom_range(0, 199);
      if      (r < 2)  st = S_RST;
      else if (r < 4)  st = S_INI;
      else if (r < 100) st = S_IDL;
      else             st = S_ACT;
      tick(($urandom_range(0, 199) != 0), st, 5'($urandom), 1'($urandom), 3'($urandom));
    end

    tick(1, S_IDL, 5'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counters_bank.md
Name: counters_bank

Overview:
Parametrised bank of per-channel event counters for the transaction-layer datapath. It replaces the single fixed-width counter set.
- One counter per FIFO/channel, incremented on that channel's pop strobe.
- Read-out is a request/index handshake, gated by the top-level one-hot state.
- Adds selectable saturate/wrap mode, sticky overflow flags, optional clear-on-read and an aggregate total counter.

Parameters:
NUM_CH, 5, number of channels/counters (1..8)
IDX_W, 3, width of idx; NUM_CH <= 2**IDX_W
CNT_W, 5, width of each per-channel counter
SATURATE, 1, 1: counters stick at max; 0: counters wrap to 0
CLR_ON_READ, 0, 1: counter of the read channel is cleared on an accepted read

Ports:
clk  input  1  clock; all logic on rising edge
reset_L  input  1  synchronous reset, active low
state  input  4  top FSM one-hot: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
pop  input  NUM_CH  per-channel event strobe, one count per cycle high
req  input  1  read request
idx  input  IDX_W  channel selected for read
counts  output  CNT_W  registered read data
counts_valid  output  1  one-cycle pulse, counts is valid
counts_total  output  CNT_W+3  running sum of all events, registered
ovf  output  NUM_CH  sticky per-channel overflow flags
idx_err  output  1  one-cycle pulse, read of idx >= NUM_CH

Behaviour:
- Reset: reset_L low at a rising edge clears all counters, counts, counts_valid, counts_total, ovf and idx_err to 0. Reset has priority over every other event.
- state == RESET or INIT:
  - all counters, counts_total and ovf are held at 0;
  - pop and req are ignored;
  - counts and counts_valid go to 0.
- state == ACTIVE or IDLE: counting is enabled.
  - For each ch with pop[ch]=1, cnt[ch] increments by 1.
  - counts_total increments by popcount(pop) in the same cycle.
- Overflow:
  - Overflow occurs when cnt[ch] is at 2**CNT_W-1 and is incremented.
  - SATURATE=1: cnt stays at max. SATURATE=0: cnt wraps to 0.
  - In both modes ovf[ch] is set and stays set until reset or RESET/INIT state.
  - counts_total follows the same mode at its own width, but has no ovf flag.
- Read handshake, accepted only when state == IDLE and req=1:
  - One cycle after acceptance: counts_valid=1 and counts = cnt[idx] as sampled at the accepting edge, i.e. the value before any same-cycle pop is applied.
  - Latency 1 cycle. req held high issues a read every cycle. Back-to-back reads are allowed with no bubble.
  - When no read is accepted, counts_valid=0 and counts holds its last value.
  - req while state == ACTIVE is ignored, no response.
- Clear-on-read (CLR_ON_READ=1): the read channel's counter is cleared at the accepting edge.
  - Same-cycle pop on that channel: cnt becomes 1; the event is not lost.
  - ovf is not cleared by a read.
- Out-of-range read (idx >= NUM_CH, accepted): counts=0, counts_valid=1, idx_err=1 for one cycle. No counter is modified.
- State changes mid-count: leaving IDLE/ACTIVE for RESET/INIT clears everything on the next edge, exactly like reset_L, except reset_L remains high.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset clears: drive counters nonzero, then reset_L=0 for one edge -> all outputs 0. Repeat via state=0001 -> same result.
2. Count and read (defaults):
   - state=1000; pop[0] for 3 cycles, pop[2] for 1 cycle.
   - state=0100; req=1 with idx=0, then idx=2 on back-to-back cycles.
   - Expect counts=3 then counts=1, each with counts_valid high one cycle after its req.
   - Expect counts_total=4.
3. Saturate vs wrap:
   - SATURATE=1: 33 pops on ch1 -> read gives 31 and ovf[1]=1.
   - SATURATE=0: same stimulus -> read gives 1 and ovf[1]=1.
4. Clear-on-read collision (CLR_ON_READ=1):
   - cnt[3]=5; in IDLE assert req with idx=3 and pop[3] in the same cycle.
   - Expect counts=5; a following read gives 1.
5. Illegal accesses:
   - req with idx=4 in IDLE when NUM_CH=4 -> counts=0, counts_valid=1, idx_err=1, counters unchanged.
   - req while state=1000 -> counts_valid stays 0.
6. Mid-operation reset: reset_L=0 on the same edge as an accepted req and a pop -> next cycle counts_valid=0 and all counters 0.
